regfile_write_arbiter: RTL and testbench

Shares the single write port of the 32×32 register file between two writeback requesters, port A (ALU writeback) and port B (load writeback). Each requester presents an address/data pair with a Req/Ack handshake. The arbiter picks one winner per cycle, registers the winning write onto the register-file write port (`WriteRegister`, `WriteData`, `RegWrite`), and keeps a running count of committed writes. It sits directly in front of `regfile` and is the only driver of its write port.

---
 rtl/regfile_write_arbiter.sv | 141 ++++++++++++++
 tb/tb_regfile_write_arbiter.sv | 356 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_write_arbiter.sv
// ============================================================================
// Module   : regfile_write_arbiter
// Purpose  : Shares the single register-file write port between two writeback
//            requesters (A = ALU writeback, B = load writeback). One winner is
//            picked per cycle, its address/data are registered onto the
//            register-file write port, and committed writes are counted.
// Ports    : Clk, Reset_n            - clock, async active-low reset
//            ReqA/AddrA/DataA/AckA  - requester A handshake and payload
//            ReqB/AddrB/DataB/AckB  - requester B handshake and payload
//            WriteRegister/WriteData/RegWrite - register-file write port
//            Busy                   - any request pending or write in flight
//            WriteCount             - committed writes, wraps mod 2^CNT_W
// Config   : REGFILE_ARB_FIXED_PRI_EN - when defined, A wins every tie and
//            the round-robin Last register is not built.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module regfile_write_arbiter #(
   parameter int ADDR_W = 5,
   parameter int DATA_W = 32,
   parameter int CNT_W  = 16
) (
   input  logic              Clk,
   input  logic              Reset_n,
   input  logic              ReqA,
   input  logic [ADDR_W-1:0] AddrA,
   input  logic [DATA_W-1:0] DataA,
   output logic              AckA,
   input  logic              ReqB,
   input  logic [ADDR_W-1:0] AddrB,
   input  logic [DATA_W-1:0] DataB,
   output logic              AckB,
   output logic [ADDR_W-1:0] WriteRegister,
   output logic [DATA_W-1:0] WriteData,
   output logic              RegWrite,
   output logic              Busy,
   output logic [CNT_W-1:0]  WriteCount
);

   // Registered state
   logic              ack_a_q,    ack_a_d;
   logic              ack_b_q,    ack_b_d;
   logic [ADDR_W-1:0] wreg_q,     wreg_d;
   logic [DATA_W-1:0] wdata_q,    wdata_d;
   logic              regwrite_q, regwrite_d;
   logic [CNT_W-1:0]  cnt_q,      cnt_d;

   // Arbitration
   logic              elig_a_w;
   logic              elig_b_w;
   logic              grant_a_w;
   logic              grant_b_w;
   logic [ADDR_W-1:0] sel_addr_w;
   logic [DATA_W-1:0] sel_data_w;

   // A requester still showing its Ack is locked out for that cycle so a
   // held Req cannot be accepted twice.
   assign elig_a_w = ReqA & ~ack_a_q;
   assign elig_b_w = ReqB & ~ack_b_q;

`ifdef REGFILE_ARB_FIXED_PRI_EN
   assign grant_a_w = elig_a_w;
`else
   typedef enum logic {
      LAST_A = 1'b0,
      LAST_B = 1'b1
   } last_t;

   last_t last_q, last_d;

   // A wins unless B is also eligible and A was the most recent winner.
   assign grant_a_w = elig_a_w & (~elig_b_w | (last_q == LAST_B));

   always_comb begin
      last_d = last_q;
      if (grant_a_w) begin
         last_d = LAST_A;
      end else if (grant_b_w) begin
         last_d = LAST_B;
      end
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         last_q <= LAST_B;
      end else begin
         last_q <= last_d;
      end
   end
`endif

   assign grant_b_w  = elig_b_w & ~grant_a_w;
   assign sel_addr_w = grant_a_w ? AddrA : AddrB;
   assign sel_data_w = grant_a_w ? DataA : DataB;

   always_comb begin
      ack_a_d    = grant_a_w;
      ack_b_d    = grant_b_w;
      wreg_d     = wreg_q;
      wdata_d    = wdata_q;
      regwrite_d = 1'b0;
      if (grant_a_w || grant_b_w) begin
         wreg_d     = sel_addr_w;
         wdata_d    = sel_data_w;
         // r0 is hardwired zero: the request is acknowledged but not written.
         regwrite_d = (sel_addr_w != '0);
      end
      // Count at the edge where the register file actually commits.
      cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, regwrite_q};
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         ack_a_q    <= 1'b0;
         ack_b_q    <= 1'b0;
         wreg_q     <= '0;
         wdata_q    <= '0;
         regwrite_q <= 1'b0;
         cnt_q      <= '0;
      end else begin
         ack_a_q    <= ack_a_d;
         ack_b_q    <= ack_b_d;
         wreg_q     <= wreg_d;
         wdata_q    <= wdata_d;
         regwrite_q <= regwrite_d;
         cnt_q      <= cnt_d;
      end
   end

   assign AckA          = ack_a_q;
   assign AckB          = ack_b_q;
   assign WriteRegister = wreg_q;
   assign WriteData     = wdata_q;
   assign RegWrite      = regwrite_q;
   assign WriteCount    = cnt_q;
   assign Busy          = ReqA | ReqB | regwrite_q;

endmodule

`default_nettype wire

// File: tb/tb_regfile_write_arbiter.sv
// ============================================================================
// Module   : tb_regfile_write_arbiter
// Purpose  : Self-checking bench for regfile_write_arbiter. Expected writes
//            are queued when requests are driven and compared when an Ack
//            appears; a small register-file model records committed writes.
//            The counter is built 8 bits wide so the wrap is reachable.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_regfile_write_arbiter;

   localparam int AW = 5;
   localparam int DW = 32;
   localparam int CW = 8;

   logic          Clk = 1'b0;
   logic          Reset_n;
   logic          ReqA, ReqB;
   logic [AW-1:0] AddrA, AddrB;
   logic [DW-1:0] DataA, DataB;
   logic          AckA, AckB;
   logic [AW-1:0] WriteRegister;
   logic [DW-1:0] WriteData;
   logic          RegWrite;
   logic          Busy;
   logic [CW-1:0] WriteCount;

   typedef struct packed {
      logic          port;   // 0 = A, 1 = B
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
      logic          rw;
   } exp_t;

   exp_t          sb[$];
   logic [DW-1:0] rf_model [32];
   logic [CW-1:0] exp_cnt;
   int            errors = 0;
   int            checks = 0;

   regfile_write_arbiter #(.ADDR_W(AW), .DATA_W(DW), .CNT_W(CW)) dut (
      .Clk(Clk), .Reset_n(Reset_n),
      .ReqA(ReqA), .AddrA(AddrA), .DataA(DataA), .AckA(AckA),
      .ReqB(ReqB), .AddrB(AddrB), .DataB(DataB), .AckB(AckB),
      .WriteRegister(WriteRegister), .WriteData(WriteData),
      .RegWrite(RegWrite), .Busy(Busy), .WriteCount(WriteCount)
   );

   always #5 Clk = ~Clk;

   initial for (int i = 0; i < 32; i++) rf_model[i] = '0;

   // Register-file model: commits on the edge that ends a RegWrite cycle.
   always @(posedge Clk) begin
      if (Reset_n && RegWrite) rf_model[WriteRegister] <= WriteData;
   end

   // Scoreboard monitor: every Ack must match the next queued write.
   always @(negedge Clk) begin
      exp_t e;
      if (Reset_n) begin
         if (AckA || AckB) begin
            checks++;
            if (AckA && AckB) begin
               errors++;
               $display("FAIL ack_overlap: AckA=%0b AckB=%0b, required at most one", AckA, AckB);
            end
            checks++;
            if (sb.size() == 0) begin
               errors++;
               $display("FAIL unexpected_ack: AckA=%0b AckB=%0b with no write expected", AckA, AckB);
            end else begin
               e = sb.pop_front();
               if ({AckB, WriteRegister, WriteData, RegWrite} !== {e.port, e.addr, e.data, e.rw}) begin
                  errors++;
                  $display("FAIL sb_write: got port=%0b reg=%0d data=%0d rw=%0b, required port=%0b reg=%0d data=%0d rw=%0b",
                           AckB, WriteRegister, WriteData, RegWrite, e.port, e.addr, e.data, e.rw);
               end
            end
         end else if (RegWrite) begin
            checks++;
            errors++;
            $display("FAIL regwrite_no_ack: RegWrite=1 without Ack, required 0");
         end
      end
   end

   task automatic test_reset();
      int n;
      Reset_n = 1'b0;
      ReqA = 1'b1; AddrA = 5'd1; DataA = 32'd11;
      ReqB = 1'b0; AddrB = '0;   DataB = '0;
      repeat (3) @(negedge Clk);
      checks++;
      if ({AckA, AckB, RegWrite} !== 3'b000) begin
         errors++; $display("FAIL reset_ctrl: Acks/RegWrite=%b, required 000", {AckA, AckB, RegWrite});
      end
      checks++;
      if (WriteRegister !== '0 || WriteData !== '0 || WriteCount !== '0) begin
         errors++; $display("FAIL reset_data: reg=%0d data=%0d cnt=%0d, required 0 0 0", WriteRegister, WriteData, WriteCount);
      end
      checks++;
      if (Busy !== 1'b1) begin
         errors++; $display("FAIL reset_busy: Busy=%0b, required 1", Busy);
      end
      // Tie right after release: A must win first, then B.
      ReqB = 1'b1; AddrB = 5'd7; DataB = 32'd77;
      sb.push_back('{1'b0, 5'd1, 32'd11, 1'b1});
      sb.push_back('{1'b1, 5'd7, 32'd77, 1'b1});
      Reset_n = 1'b1;
      n = 0;
      do begin @(negedge Clk); n++; end while (!AckA && n < 10);
      checks++;
      if (!AckA || n != 1) begin
         errors++; $display("FAIL reset_first_grant: AckA=%0b after %0d cycles, required 1 after 1", AckA, n);
      end
      ReqA = 1'b0;
      n = 0;
      do begin @(negedge Clk); n++; end while (!AckB && n < 10);
      checks++;
      if (!AckB) begin
         errors++; $display("FAIL reset_second_grant: AckB=%0b, required 1", AckB);
      end
      ReqB = 1'b0;
      exp_cnt = 8'd2;
      @(negedge Clk);
   endtask

   task automatic test_single_write();
      int n;
      ReqA = 1'b1; AddrA = 5'd2; DataA = 32'd42;
      sb.push_back('{1'b0, 5'd2, 32'd42, 1'b1});
      n = 0;
      do begin @(negedge Clk); n++; end while (!AckA && n < 10);
      checks++;
      if (!AckA || n != 1 || RegWrite !== 1'b1 || Busy !== 1'b1) begin
         errors++; $display("FAIL single_latency: AckA=%0b n=%0d RegWrite=%0b Busy=%0b, required 1 1 1 1", AckA, n, RegWrite, Busy);
      end
      ReqA = 1'b0;
      exp_cnt = exp_cnt + 8'd1;
      @(negedge Clk);
      checks++;
      if (WriteCount !== exp_cnt || rf_model[2] !== 32'd42) begin
         errors++; $display("FAIL single_commit: cnt=%0d r2=%0d, required %0d 42", WriteCount, rf_model[2], exp_cnt);
      end
      checks++;
      if (Busy !== 1'b0 || RegWrite !== 1'b0) begin
         errors++; $display("FAIL single_idle: Busy=%0b RegWrite=%0b, required 0 0", Busy, RegWrite);
      end
   endtask

   task automatic test_reg0_drop();
      int n;
      ReqB = 1'b1; AddrB = 5'd0; DataB = 32'd33;
      sb.push_back('{1'b1, 5'd0, 32'd33, 1'b0});
      n = 0;
      do begin @(negedge Clk); n++; end while (!AckB && n < 10);
      checks++;
      if (!AckB || RegWrite !== 1'b0) begin
         errors++; $display("FAIL reg0_ack: AckB=%0b RegWrite=%0b, required 1 0", AckB, RegWrite);
      end
      ReqB = 1'b0;
      repeat (2) @(negedge Clk);
      checks++;
      if (WriteCount !== exp_cnt || rf_model[0] !== 32'd0) begin
         errors++; $display("FAIL reg0_nocount: cnt=%0d r0=%0d, required %0d 0", WriteCount, rf_model[0], exp_cnt);
      end
   endtask

   task automatic test_contention();
      ReqA = 1'b1; AddrA = 5'd3; DataA = 32'd43;
      ReqB = 1'b1; AddrB = 5'd4; DataB = 32'd44;
      for (int i = 0; i < 6; i++) begin
         if (i % 2 == 0) sb.push_back('{1'b0, 5'd3, 32'd43, 1'b1});
         else            sb.push_back('{1'b1, 5'd4, 32'd44, 1'b1});
      end
      for (int i = 0; i < 6; i++) begin
         @(negedge Clk);
         checks++;
         if ({AckA, AckB} !== ((i % 2 == 0) ? 2'b10 : 2'b01)) begin
            errors++; $display("FAIL contention_alt[%0d]: AckA/AckB=%b, required %b", i, {AckA, AckB}, (i % 2 == 0) ? 2'b10 : 2'b01);
         end
      end
      ReqA = 1'b0; ReqB = 1'b0;
      exp_cnt = exp_cnt + 8'd6;
      @(negedge Clk);
      checks++;
      if (WriteCount !== exp_cnt || rf_model[3] !== 32'd43 || rf_model[4] !== 32'd44) begin
         errors++; $display("FAIL contention_commit: cnt=%0d r3=%0d r4=%0d, required %0d 43 44", WriteCount, rf_model[3], rf_model[4], exp_cnt);
      end
   endtask

   task automatic test_collision();
      ReqA = 1'b1; AddrA = 5'd2; DataA = 32'd26;
      ReqB = 1'b1; AddrB = 5'd2; DataB = 32'd27;
      sb.push_back('{1'b0, 5'd2, 32'd26, 1'b1});
      sb.push_back('{1'b1, 5'd2, 32'd27, 1'b1});
      @(negedge Clk);
      checks++;
      if ({AckA, AckB} !== 2'b10) begin
         errors++; $display("FAIL collision_first: AckA/AckB=%b, required 10", {AckA, AckB});
      end
      ReqA = 1'b0;
      @(negedge Clk);
      checks++;
      if ({AckA, AckB} !== 2'b01) begin
         errors++; $display("FAIL collision_second: AckA/AckB=%b, required 01", {AckA, AckB});
      end
      ReqB = 1'b0;
      exp_cnt = exp_cnt + 8'd2;
      @(negedge Clk);
      checks++;
      if (rf_model[2] !== 32'd27) begin
         errors++; $display("FAIL collision_final: r2=%0d, required 27", rf_model[2]);
      end
   endtask

   task automatic test_tie_last_a();
      logic [1:0] first_ack, second_ack;
      ReqA = 1'b1; AddrA = 5'd5; DataA = 32'd55;
      sb.push_back('{1'b0, 5'd5, 32'd55, 1'b1});
      @(negedge Clk);
      ReqA = 1'b0;
      @(negedge Clk);
      ReqA = 1'b1; AddrA = 5'd6; DataA = 32'd66;
      ReqB = 1'b1; AddrB = 5'd7; DataB = 32'd70;
`ifdef REGFILE_ARB_FIXED_PRI_EN
      first_ack = 2'b10; second_ack = 2'b01;
      sb.push_back('{1'b0, 5'd6, 32'd66, 1'b1});
      sb.push_back('{1'b1, 5'd7, 32'd70, 1'b1});
`else
      first_ack = 2'b01; second_ack = 2'b10;
      sb.push_back('{1'b1, 5'd7, 32'd70, 1'b1});
      sb.push_back('{1'b0, 5'd6, 32'd66, 1'b1});
`endif
      @(negedge Clk);
      checks++;
      if ({AckA, AckB} !== first_ack) begin
         errors++; $display("FAIL tie_first: AckA/AckB=%b, required %b", {AckA, AckB}, first_ack);
      end
      if (first_ack[1]) ReqA = 1'b0; else ReqB = 1'b0;
      @(negedge Clk);
      checks++;
      if ({AckA, AckB} !== second_ack) begin
         errors++; $display("FAIL tie_second: AckA/AckB=%b, required %b", {AckA, AckB}, second_ack);
      end
      ReqA = 1'b0; ReqB = 1'b0;
      exp_cnt = exp_cnt + 8'd3;
      @(negedge Clk);
   endtask

   task automatic test_back_to_back();
      ReqA = 1'b1; AddrA = 5'd8; DataA = 32'd80;
      sb.push_back('{1'b0, 5'd8, 32'd80, 1'b1});
      for (int i = 0; i < 6; i++) begin
         @(negedge Clk);
         checks++;
         if ({AckA, AckB} !== ((i % 2 == 0) ? 2'b10 : 2'b00)) begin
            errors++; $display("FAIL b2b_rate[%0d]: AckA/AckB=%b, required %b", i, {AckA, AckB}, (i % 2 == 0) ? 2'b10 : 2'b00);
         end
         if (AckA) begin
            if (i < 4) begin
               DataA = DataA + 32'd1;
               sb.push_back('{1'b0, 5'd8, DataA, 1'b1});
            end else begin
               ReqA = 1'b0;
            end
         end
      end
      ReqA = 1'b0;
      exp_cnt = exp_cnt + 8'd3;
      checks++;
      if (WriteCount !== exp_cnt || rf_model[8] !== 32'd82) begin
         errors++; $display("FAIL b2b_commit: cnt=%0d r8=%0d, required %0d 82", WriteCount, rf_model[8], exp_cnt);
      end
   endtask

   task automatic test_reset_mid();
      int n;
      ReqA = 1'b1; AddrA = 5'd9; DataA = 32'd99;
      sb.push_back('{1'b0, 5'd9, 32'd99, 1'b1});
      n = 0;
      do begin @(negedge Clk); n++; end while (!AckA && n < 10);
      #2 Reset_n = 1'b0;
      #1;
      checks++;
      if ({AckA, RegWrite} !== 2'b00 || WriteCount !== '0 || WriteRegister !== '0) begin
         errors++; $display("FAIL reset_mid: AckA=%0b RegWrite=%0b cnt=%0d reg=%0d, required 0 0 0 0", AckA, RegWrite, WriteCount, WriteRegister);
      end
      ReqA = 1'b0;
      @(negedge Clk);
      Reset_n = 1'b1;
      exp_cnt = '0;
      @(negedge Clk);
      checks++;
      if (rf_model[9] !== 32'd0) begin
         errors++; $display("FAIL reset_mid_lost: r9=%0d, required 0", rf_model[9]);
      end
   endtask

   task automatic test_counter_wrap();
      int n;
      for (int i = 0; i < 256; i++) begin
         ReqA = 1'b1; AddrA = 5'((i % 31) + 1); DataA = i;
         sb.push_back('{1'b0, 5'((i % 31) + 1), 32'(i), 1'b1});
         n = 0;
         do begin @(negedge Clk); n++; end while (!AckA && n < 10);
         if (!AckA) begin
            checks++; errors++;
            $display("FAIL wrap_timeout[%0d]: no AckA within %0d cycles", i, n);
         end
         ReqA = 1'b0;
         exp_cnt = exp_cnt + 8'd1;
         if (i == 254) begin
            @(negedge Clk);
            checks++;
            if (WriteCount !== 8'd255 || WriteCount !== exp_cnt) begin
               errors++; $display("FAIL wrap_full: cnt=%0d, required 255", WriteCount);
            end
         end
      end
      @(negedge Clk);
      checks++;
      if (WriteCount !== 8'd0) begin
         errors++; $display("FAIL wrap_zero: cnt=%0d, required 0", WriteCount);
      end
   endtask

   initial begin
      Reset_n = 1'b0;
      ReqA = 1'b0; AddrA = '0; DataA = '0;
      ReqB = 1'b0; AddrB = '0; DataB = '0;
      exp_cnt = '0;
      @(negedge Clk);
      test_reset();
      test_single_write();
      test_reg0_drop();
      test_contention();
      test_collision();
      test_tie_last_a();
      test_back_to_back();
      test_reset_mid();
      test_counter_wrap();
      repeat (2) @(negedge Clk);
      checks++;
      if (sb.size() != 0) begin
         errors++; $display("FAIL sb_drain: %0d writes never acknowledged, required 0", sb.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

`default_nettype wire
